regfile_param: RTL

REGFILE_PARAM -- requirements
Module: regfile_param
Interface
REQ-001 Parameter DATA_W, default 32, register and data width in bits.
REQ-002 Parameter NREGS, default 16, register count (power of two, >=4); AW = log2(NREGS) is a derived constant.
REQ-003 Parameter NRD, default 3, number of read ports.
REQ-004 Parameter PC_IDX, default 15, index of the PC register.
REQ-005 Parameter LR_IDX, default 14, index of the link register.
REQ-006 Parameter LINK_OFS, default 4, value subtracted from PC_IN for the link write.
REQ-007 CLK  in  1  single clock; all state changes on posedge.
REQ-008 RST  in  1  reset; synchronous, active-high.
REQ-009 CLR  in  1  one-cycle pulse; starts a soft clear of all registers.
REQ-010 WE  in  1  general write enable.
REQ-011 WA  in  AW  general write address.
REQ-012 WD  in  DATA_W  general write data.
REQ-013 LINK_WE  in  1  BL link write: R[LR_IDX] <= PC_IN - LINK_OFS.
REQ-014 PC_IN  in  DATA_W  PC value, written to R[PC_IDX] every active cycle.
REQ-015 RA  in  NRD*AW  packed read addresses; port k uses bits [k*AW +: AW].
REQ-016 RD  out  NRD*DATA_W  packed registered read data; port k uses bits [k*DATA_W +: DATA_W].
REQ-017 BUSY  out  1  high while a clear sequence is running.
Function
REQ-018 The FSM SHALL have two states: IDLE and CLEAR.
REQ-019 In CLEAR: each cycle R[cnt] <= 0 and cnt++; when cnt==NREGS-1, next state IDLE; the sequence lasts exactly NREGS cycles.
REQ-020 In IDLE, CLR=1 SHALL enter CLEAR with cnt=0 next cycle; CLR in CLEAR SHALL be ignored.
REQ-021 BUSY SHALL be 1 exactly while state==CLEAR.
REQ-022 In CLEAR, WE, LINK_WE and the PC_IN update SHALL be ignored and every RD port SHALL register 0.
REQ-023 In IDLE, each cycle: R[PC_IDX] <= PC_IN; if WE, R[WA] <= WD; if LINK_WE, R[LR_IDX] <= PC_IN - LINK_OFS (modulo 2^DATA_W).
REQ-024 Same-register priority: LINK_WE over WE at LR_IDX; WE over PC_IN at PC_IDX.
REQ-025 Read latency SHALL be one cycle: RD port k at edge n+1 reflects RA port k sampled at edge n.
REQ-026 Reads SHALL bypass: if RA port k addresses a register written at the same edge, RD port k SHALL register the newly written value (after REQ-024 priority), never the old one.
REQ-027 Any number of read ports MAY address the same register; all SHALL return the same value.
REQ-028 The write address SHALL be WA itself, never previously registered read data.
Reset
REQ-029 RST=1 SHALL force state CLEAR, cnt=0, BUSY=1 and RD=0 on the next edge, overriding CLR, WE and LINK_WE.
REQ-030 RST asserted mid-clear SHALL restart the sequence from cnt=0; after RST deasserts, BUSY falls NREGS cycles later.
REQ-031 Register contents are undefined until the first clear completes; no RD value is observable before then (RD=0 during CLEAR).
Structure
REQ-032 State encoding (IDLE/CLEAR) and default values of PC_IDX, LR_IDX and LINK_OFS SHALL live in the shared package regfile_pkg.
REQ-033 The clear FSM and counter SHALL be the sub-module regfile_clear_ctl (outputs BUSY, clear enable, clear index); storage, write priority and bypass stay in regfile_param.
REQ-034 Storage SHALL be a flat array of NREGS x DATA_W flops; no negedge logic and no latches.
Verification
REQ-035 Reset: RST for 1 cycle -> BUSY=1 for 16 cycles, then 0; all RD=0 throughout; then reading R0..R13 -> 0.
REQ-036 Write/read: WE=1, WA=3, WD=0xDEADBEEF; next cycle RA0=3 -> RD0=0xDEADBEEF one cycle later; RA1=RA2=3 give the same value.
REQ-037 Bypass: WE=1, WA=5, WD=0x12345678 with RA0=5 in the same cycle -> RD0=0x12345678 next cycle.
REQ-038 Link/PC: PC_IN=0x00000100, LINK_WE=1, WE=1, WA=14, WD=0xAAAA -> R14=0x000000FC; PC_IN only -> R15=0x100; WE=1, WA=15, WD=0x200 -> R15=0x200.
REQ-039 Clear abort/restart: CLR pulse, RST at clear cycle 7 -> BUSY stays high 16 further cycles; a WE during CLEAR has no effect (register reads 0 afterwards).
REQ-040 Parameter sweep: DATA_W=16, NREGS=8, NRD=4 -> clear lasts 8 cycles; PC_IN=0x0002 with LINK_WE -> R[LR_IDX]=0xFFFE (wrap).

---
 rtl/regfile_pkg.sv | 18 +
 rtl/regfile_if.sv | 28 ++
 rtl/regfile_clear_ctl.sv | 52 +++++
 rtl/regfile_param.sv | 68 ++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the parameterised register file.
// Holds the clear-sequencer state encoding and the special-register defaults.
package regfile_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam int DEF_PC_IDX   = 15;
  localparam int DEF_LR_IDX   = 14;
  localparam int DEF_LINK_OFS = 4;

  function automatic int addr_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/regfile_if.sv
// Write/read/clear bus of the register file; the master drives, the file answers.
interface regfile_if #(
  parameter int DATA_W = 32,
  parameter int AW     = 4,
  parameter int NRD    = 3
);

  logic                  CLR;
  logic                  WE;
  logic [AW-1:0]         WA;
  logic [DATA_W-1:0]     WD;
  logic                  LINK_WE;
  logic [DATA_W-1:0]     PC_IN;
  logic [NRD*AW-1:0]     RA;
  logic [NRD*DATA_W-1:0] RD;
  logic                  BUSY;

  modport master (
    output CLR, WE, WA, WD, LINK_WE, PC_IN, RA,
    input  RD, BUSY
  );

  modport slave (
    input  CLR, WE, WA, WD, LINK_WE, PC_IN, RA,
    output RD, BUSY
  );

endinterface

// File: rtl/regfile_clear_ctl.sv
// Soft-clear sequencer: walks an index over every register, one per cycle.
module regfile_clear_ctl
  import regfile_pkg::*;
#(
  parameter  int NREGS = 16,
  localparam int AW    = addr_w(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  output logic          busy,
  output logic          clr_en,
  output logic [AW-1:0] clr_idx
);

  state_t        state;
  logic [AW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
      busy  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (clr) begin
            state <= CLEAR;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        CLEAR: begin
          cnt <= cnt + AW'(1);
          if (cnt == AW'(NREGS - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= CLEAR;
          cnt   <= '0;
          busy  <= 1'b1;
        end
      endcase
    end
  end

  assign clr_en  = busy;
  assign clr_idx = cnt;

endmodule

// File: rtl/regfile_param.sv
// Parameterised register file with PC/link special registers, write-through
// read bypass on every port, and a one-register-per-cycle soft clear.
module regfile_param
  import regfile_pkg::*;
#(
  parameter  int DATA_W   = 32,
  parameter  int NREGS    = 16,
  parameter  int NRD      = 3,
  parameter  int PC_IDX   = DEF_PC_IDX,
  parameter  int LR_IDX   = DEF_LR_IDX,
  parameter  int LINK_OFS = DEF_LINK_OFS,
  localparam int AW       = addr_w(NREGS)
) (
  input logic      CLK,
  input logic      RST,
  regfile_if.slave bus
);

  logic [DATA_W-1:0] regs     [NREGS];
  logic [DATA_W-1:0] regs_nxt [NREGS];
  logic [DATA_W-1:0] rd_q     [NRD];
  logic              busy;
  logic              clr_en;
  logic [AW-1:0]     clr_idx;

  regfile_clear_ctl #(.NREGS(NREGS)) u_clear_ctl (
    .clk     (CLK),
    .rst     (RST),
    .clr     (bus.CLR),
    .busy    (busy),
    .clr_en  (clr_en),
    .clr_idx (clr_idx)
  );

  // Statement order encodes priority: WE beats PC_IN, LINK_WE beats WE.
  always_comb begin
    regs_nxt = regs;
    if (!RST) begin
      if (clr_en) begin
        regs_nxt[clr_idx] = '0;
      end else begin
        regs_nxt[AW'(PC_IDX)] = bus.PC_IN;
        if (bus.WE)
          regs_nxt[bus.WA] = bus.WD;
        if (bus.LINK_WE)
          regs_nxt[AW'(LR_IDX)] = bus.PC_IN - DATA_W'(LINK_OFS);
      end
    end
  end

  // Reads look up the post-write image so same-edge writes bypass to RD.
  always_ff @(posedge CLK) begin
    regs <= regs_nxt;
    for (int unsigned k = 0; k < NRD; k++) begin
      if (RST || clr_en)
        rd_q[k] <= '0;
      else
        rd_q[k] <= regs_nxt[bus.RA[k*AW +: AW]];
    end
  end

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    assign bus.RD[g*DATA_W +: DATA_W] = rd_q[g];
  end

  assign bus.BUSY = busy;

endmodule
